id_stage_pipe: RTL

//  Parametrised decode stage for the 5-stage MIPS pipeline, successor to the flat decode block.

---
 rtl/mips_pkg.sv | 34 +++
 rtl/id_stage_pipe_if.sv | 42 ++++
 rtl/id_stage_pipe_regfile_bypass.sv | 50 +++++
 rtl/id_stage_pipe.sv | 111 +++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Opcode constants and small decode helpers shared by the MIPS pipeline stages.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic [1:0] {
        EXT_SIGN = 2'd0,
        EXT_ZERO = 2'd1,
        EXT_LUI  = 2'd2
    } extKind_e;

    // Logical immediates are unsigned, LUI places the immediate high, everything else sign-extends.
    function automatic extKind_e extKind(input logic [5:0] op);
        case (op)
            OP_ANDI, OP_ORI, OP_XORI: return EXT_ZERO;
            OP_LUI:                   return EXT_LUI;
            default:                  return EXT_SIGN;
        endcase
    endfunction

    // Instructions whose rt field is a source operand rather than a destination.
    function automatic logic usesRt(input logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
    endfunction

endpackage

// File: rtl/id_stage_pipe_if.sv
// Decode-stage bus: IF/ID and WB inputs toward the stage, ID/EX register contents out of it.
interface id_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    logic [31:0]           instr_d;
    logic                  valid_d;
    logic [DATA_W-1:0]     pc_plus4_d;
    logic                  reg_write_w;
    logic [REG_ADDR_W-1:0] reg_write_addr_w;
    logic [DATA_W-1:0]     reg_write_data_w;
    logic                  hold_e;
    logic                  flush_e;

    logic                  stall_d;
    logic                  valid_e;
    logic [DATA_W-1:0]     rd1_e;
    logic [DATA_W-1:0]     rd2_e;
    logic [DATA_W-1:0]     imm_e;
    logic [REG_ADDR_W-1:0] rs_e;
    logic [REG_ADDR_W-1:0] rt_e;
    logic [REG_ADDR_W-1:0] rd_e;
    logic [4:0]            shamt_e;
    logic [5:0]            opcode_e;
    logic [5:0]            funct_e;
    logic [DATA_W-1:0]     pc_plus4_e;

    modport master (
        output instr_d, valid_d, pc_plus4_d, reg_write_w, reg_write_addr_w, reg_write_data_w,
               hold_e, flush_e,
        input  stall_d, valid_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, rd_e, shamt_e, opcode_e,
               funct_e, pc_plus4_e
    );

    modport slave (
        input  instr_d, valid_d, pc_plus4_d, reg_write_w, reg_write_addr_w, reg_write_data_w,
               hold_e, flush_e,
        output stall_d, valid_e, rd1_e, rd2_e, imm_e, rs_e, rt_e, rd_e, shamt_e, opcode_e,
               funct_e, pc_plus4_e
    );

endinterface

// File: rtl/id_stage_pipe_regfile_bypass.sv
// Two-read, one-write register file with optional write-through from WB and optional hardwired r0.
module regfile_bypass #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS_WB  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [REG_ADDR_W-1:0] rdAddr1,
    input  logic [REG_ADDR_W-1:0] rdAddr2,
    output logic [DATA_W-1:0]     rdData1,
    output logic [DATA_W-1:0]     rdData2,
    input  logic                  wrEn,
    input  logic [REG_ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0]     wrData
);

    localparam int unsigned DEPTH = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wrAccept;

    // A write to r0 is dropped entirely when r0 is hardwired, so it never bypasses either.
    assign wrAccept = wrEn && !((ZERO_REG != 0) && (wrAddr == '0));

    // Storage: clear the whole file on reset, otherwise commit the accepted WB write.
    always_ff @(posedge clk) begin
        if (rst) begin
            regs <= '{default: '0};
        end else if (wrAccept) begin
            regs[wrAddr] <= wrData;
        end
    end

    // Read port 1: hardwired zero first, then same-cycle WB data, then stored value.
    always_comb begin
        rdData1 = regs[rdAddr1];
        if ((BYPASS_WB != 0) && wrAccept && (wrAddr == rdAddr1)) rdData1 = wrData;
        if ((ZERO_REG != 0) && (rdAddr1 == '0)) rdData1 = '0;
    end

    // Read port 2: same selection as port 1.
    always_comb begin
        rdData2 = regs[rdAddr2];
        if ((BYPASS_WB != 0) && wrAccept && (wrAddr == rdAddr2)) rdData2 = wrData;
        if ((ZERO_REG != 0) && (rdAddr2 == '0)) rdData2 = '0;
    end

endmodule

// File: rtl/id_stage_pipe.sv
// MIPS decode stage: register read, immediate extension, load-use hazard detection and the ID/EX register.
module id_stage_pipe
    import mips_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS_WB  = 1
) (
    input logic           clk,
    input logic           rst,
    id_stage_pipe_if.slave idBus
);

    logic [5:0]            opcodeD;
    logic [REG_ADDR_W-1:0] rsD, rtD, rdD;
    logic [15:0]           imm16D;
    logic [DATA_W-1:0]     rd1D, rd2D, immD;
    logic                  hazard;

    logic                  validE;
    logic [DATA_W-1:0]     rd1E, rd2E, immE, pcPlus4E;
    logic [REG_ADDR_W-1:0] rsE, rtE, rdE;
    logic [4:0]            shamtE;
    logic [5:0]            opcodeE, functE;

    assign opcodeD = idBus.instr_d[31:26];
    assign rsD     = REG_ADDR_W'(idBus.instr_d[25:21]);
    assign rtD     = REG_ADDR_W'(idBus.instr_d[20:16]);
    assign rdD     = REG_ADDR_W'(idBus.instr_d[15:11]);
    assign imm16D  = idBus.instr_d[15:0];

    regfile_bypass #(
        .DATA_W     (DATA_W),
        .REG_ADDR_W (REG_ADDR_W),
        .ZERO_REG   (ZERO_REG),
        .BYPASS_WB  (BYPASS_WB)
    ) uRegfile (
        .clk     (clk),
        .rst     (rst),
        .rdAddr1 (rsD),
        .rdAddr2 (rtD),
        .rdData1 (rd1D),
        .rdData2 (rd2D),
        .wrEn    (idBus.reg_write_w),
        .wrAddr  (idBus.reg_write_addr_w),
        .wrData  (idBus.reg_write_data_w)
    );

    // Immediate extension selected by opcode class.
    always_comb begin
        immD = DATA_W'($signed(imm16D));
        case (extKind(opcodeD))
            EXT_ZERO: immD = DATA_W'(imm16D);
            EXT_LUI:  immD = DATA_W'({imm16D, 16'h0000});
            default:  immD = DATA_W'($signed(imm16D));
        endcase
    end

    // Load-use hazard: a load in EX whose destination the decoding instruction reads.
    always_comb begin
        hazard = 1'b0;
        if (validE && (opcodeE == OP_LW) && (rtE != '0) && idBus.valid_d) begin
            hazard = (rsD == rtE) || (usesRt(opcodeD) && (rtD == rtE));
        end
    end

    assign idBus.stall_d = hazard | idBus.hold_e;

    // ID/EX register: reset, flush and an unheld hazard all load a zeroed bubble; hold keeps everything.
    always_ff @(posedge clk) begin
        if (rst || idBus.flush_e || (!idBus.hold_e && hazard)) begin
            validE   <= 1'b0;
            rd1E     <= '0;
            rd2E     <= '0;
            immE     <= '0;
            rsE      <= '0;
            rtE      <= '0;
            rdE      <= '0;
            shamtE   <= '0;
            opcodeE  <= '0;
            functE   <= '0;
            pcPlus4E <= '0;
        end else if (!idBus.hold_e) begin
            validE   <= idBus.valid_d;
            rd1E     <= rd1D;
            rd2E     <= rd2D;
            immE     <= immD;
            rsE      <= rsD;
            rtE      <= rtD;
            rdE      <= rdD;
            shamtE   <= idBus.instr_d[10:6];
            opcodeE  <= opcodeD;
            functE   <= idBus.instr_d[5:0];
            pcPlus4E <= idBus.pc_plus4_d;
        end
    end

    assign idBus.valid_e    = validE;
    assign idBus.rd1_e      = rd1E;
    assign idBus.rd2_e      = rd2E;
    assign idBus.imm_e      = immE;
    assign idBus.rs_e       = rsE;
    assign idBus.rt_e       = rtE;
    assign idBus.rd_e       = rdE;
    assign idBus.shamt_e    = shamtE;
    assign idBus.opcode_e   = opcodeE;
    assign idBus.funct_e    = functE;
    assign idBus.pc_plus4_e = pcPlus4E;

endmodule
